// File: rtl/display_mux_scheduler.sv
// Two-digit seven-segment scan scheduler with dead-time blanking.
// Both digit values are latched together once per frame, so the two digits never tear.
module display_mux_scheduler #(
    parameter int SHOW_CYCLES  = 5000,
    parameter int BLANK_CYCLES = 100,
    parameter int CNT_W        = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] hex_out,
    output logic       blank,
    output logic       select0,
    output logic       select1,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        SHOW0  = 2'd1,
        BLANK1 = 2'd2,
        SHOW1  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [3:0]       r_d0, r_d1, w_d0_n, w_d1_n;
    logic [3:0]       r_hex, w_hex_n;
    logic             r_blank, w_blank_n;
    logic             r_sel0, w_sel0_n;
    logic             r_sel1, w_sel1_n;
    logic             r_tick, w_tick_n;
    logic             w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BLANK0;
            r_cnt   <= '0;
            r_d0    <= 4'h0;
            r_d1    <= 4'h0;
            r_hex   <= 4'h0;
            r_blank <= 1'b1;
            r_sel0  <= 1'b1;
            r_sel1  <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_d0    <= w_d0_n;
            r_d1    <= w_d1_n;
            r_hex   <= w_hex_n;
            r_blank <= w_blank_n;
            r_sel0  <= w_sel0_n;
            r_sel1  <= w_sel1_n;
            r_tick  <= w_tick_n;
        end
    end

    always_comb begin
        w_last = 1'b0;
        unique case (r_state)
            BLANK0, BLANK1: w_last = (r_cnt == BLANK_LAST);
            SHOW0, SHOW1:   w_last = (r_cnt == SHOW_LAST);
            default:        w_last = 1'b0;
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + CNT_W'(1);
        w_d0_n    = r_d0;
        w_d1_n    = r_d1;
        w_tick_n  = 1'b0;
        if (!en) begin
            // Disabled: park dark at the top of a frame, tracking live inputs
            w_state_n = BLANK0;
            w_cnt_n   = '0;
            w_d0_n    = s0;
            w_d1_n    = s1;
        end else if (w_last) begin
            w_cnt_n = '0;
            unique case (r_state)
                BLANK0: w_state_n = SHOW0;
                SHOW0:  w_state_n = BLANK1;
                BLANK1: w_state_n = SHOW1;
                SHOW1: begin
                    w_state_n = BLANK0;
                    w_d0_n    = s0;
                    w_d1_n    = s1;
                    w_tick_n  = 1'b1;
                end
                default: w_state_n = BLANK0;
            endcase
        end
    end

    // Outputs decoded from the next state so they are registered alongside it
    always_comb begin
        w_hex_n   = w_d0_n;
        w_blank_n = 1'b1;
        w_sel0_n  = 1'b1;
        w_sel1_n  = 1'b1;
        unique case (w_state_n)
            BLANK0: w_hex_n = w_d0_n;
            SHOW0: begin
                w_hex_n   = w_d0_n;
                w_blank_n = 1'b0;
                w_sel0_n  = 1'b0;
            end
            BLANK1: w_hex_n = w_d1_n;
            SHOW1: begin
                w_hex_n   = w_d1_n;
                w_blank_n = 1'b0;
                w_sel1_n  = 1'b0;
            end
            default: w_hex_n = w_d0_n;
        endcase
    end

    assign hex_out    = r_hex;
    assign blank      = r_blank;
    assign select0    = r_sel0;
    assign select1    = r_sel1;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_display_mux_scheduler.sv
// Directed bench for display_mux_scheduler with SHOW=4, BLANK=2 (12-cycle frame).
// Output vector layout: {hex_out[3:0], blank, select0, select1, frame_tick}.
module tb_display_mux_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] hex_out;
    logic       blank;
    logic       select0;
    logic       select1;
    logic       frame_tick;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_on = 1'b0;

    display_mux_scheduler #(
        .SHOW_CYCLES (4),
        .BLANK_CYCLES(2),
        .CNT_W       (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .s0        (s0),
        .s1        (s1),
        .hex_out   (hex_out),
        .blank     (blank),
        .select0   (select0),
        .select1   (select1),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {hex_out, blank, select0, select1, frame_tick};
    endfunction

    // Expected outputs at frame phase p: 0-1 BLANK0, 2-5 SHOW0, 6-7 BLANK1, 8-11 SHOW1
    function automatic logic [7:0] exp_vec(int p, logic [3:0] e0,
                                           logic [3:0] e1, logic t);
        logic sel0, sel1;
        sel0 = !(p >= 2 && p <= 5);
        sel1 = !(p >= 8);
        return {(p < 6) ? e0 : e1, sel0 & sel1, sel0, sel1, t && (p == 0)};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            n_cmp++;
            if (!select0 && !select1) begin
                n_bad++;
                $display("FAIL invariant_selects: sel0=%b sel1=%b required not both 0",
                         select0, select1);
            end
            n_cmp++;
            if (select0 && select1 && !blank) begin
                n_bad++;
                $display("FAIL invariant_blank: blank=%b required 1 when dark", blank);
            end
        end
    end

    task automatic test_reset();
        logic [7:0] e;
        reset = 1'b1;
        en    = 1'b1;
        s0    = 4'h3;
        s1    = 4'hA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_on = 1'b1;
        n_cmp++;
        if (obs() !== 8'b0000_1110) begin
            n_bad++;
            $display("FAIL reset_values: got %b required %b", obs(), 8'b0000_1110);
        end
        reset = 1'b0;
        for (int p = 0; p < 12; p++) begin
            e = exp_vec(p, 4'h0, 4'h0, 1'b0);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL first_frame p=%0d: got %b required %b", p, obs(), e);
            end
            step();
        end
    endtask

    task automatic test_second_frame();
        logic [7:0] e;
        for (int p = 0; p < 12; p++) begin
            e = exp_vec(p, 4'h3, 4'hA, 1'b1);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL second_frame p=%0d: got %b required %b", p, obs(), e);
            end
            step();
        end
    endtask

    task automatic test_sample_hold();
        logic [7:0] e;
        for (int p = 0; p < 12; p++) begin
            e = exp_vec(p, 4'h3, 4'hA, 1'b1);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL hold_frame p=%0d: got %b required %b", p, obs(), e);
            end
            if (p == 3) s1 = 4'h5;
            step();
        end
        for (int p = 0; p < 12; p++) begin
            e = exp_vec(p, 4'h3, 4'h5, 1'b1);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL new_sample p=%0d: got %b required %b", p, obs(), e);
            end
            step();
        end
    endtask

    task automatic test_enable();
        logic [7:0] e;
        for (int p = 0; p < 10; p++) begin
            e = exp_vec(p, 4'h3, 4'h5, 1'b1);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL pre_disable p=%0d: got %b required %b", p, obs(), e);
            end
            if (p == 9) begin
                en = 1'b0;
                s0 = 4'h7;
                s1 = 4'hE;
            end
            step();
        end
        n_cmp++;
        if (obs() !== 8'b0111_1110) begin
            n_bad++;
            $display("FAIL disable_dark: got %b required %b", obs(), 8'b0111_1110);
        end
        en = 1'b1;
        step();
        for (int p = 1; p < 12; p++) begin
            e = exp_vec(p, 4'h7, 4'hE, 1'b0);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL reenable p=%0d: got %b required %b", p, obs(), e);
            end
            step();
        end
        e = exp_vec(0, 4'h7, 4'hE, 1'b1);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reenable_tick: got %b required %b", obs(), e);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        for (int p = 1; p < 4; p++) begin
            e = exp_vec(p, 4'h7, 4'hE, 1'b1);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL pre_reset p=%0d: got %b required %b", p, obs(), e);
            end
            if (p == 3) reset = 1'b1;
            step();
        end
        n_cmp++;
        if (obs() !== 8'b0000_1110) begin
            n_bad++;
            $display("FAIL mid_reset: got %b required %b", obs(), 8'b0000_1110);
        end
        reset = 1'b0;
        step();
        for (int p = 1; p < 12; p++) begin
            e = exp_vec(p, 4'h0, 4'h0, 1'b0);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL restart p=%0d: got %b required %b", p, obs(), e);
            end
            step();
        end
        e = exp_vec(0, 4'h7, 4'hE, 1'b1);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL restart_tick: got %b required %b", obs(), e);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        s0    = 4'h0;
        s1    = 4'h0;
        @(negedge clk);
        test_reset();
        test_second_frame();
        test_sample_hold();
        test_enable();
        test_reset_mid();
        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
